// File: rtl/n64_decoder_pkg.sv
// n64_decoder_pkg
//   Shared constants for the PI address decoder: bank ids, config register
//   indices, attr bit positions and the reset-default window map.
package n64_decoder_pkg;

    // Bank ids; 0 means "no window matched"
    localparam int unsigned BANK_INVALID = 0;
    localparam int unsigned BANK_ROM     = 1;
    localparam int unsigned BANK_CART    = 2;
    localparam int unsigned BANK_EEPROM  = 3;

    // Config register select
    typedef enum logic [1:0] {
        CFG_BASE = 2'd0,
        CFG_MASK = 2'd1,
        CFG_ATTR = 2'd2,
        CFG_RSVD = 2'd3
    } cfg_reg_e;

    // Attr word layout: [BANK_W-1:0] bank, [8] prefetch, [31] enable
    localparam int unsigned ATTR_PREFETCH_BIT = 8;
    localparam int unsigned ATTR_ENABLE_BIT   = 31;

    // Reset-default window map (windows 3 and above are zero / disabled)
    localparam logic [31:0] DEF_BASE_W0 = 32'h1000_0000;
    localparam logic [31:0] DEF_MASK_W0 = 32'h03FF_FFFF;
    localparam logic [7:0]  DEF_BANK_W0 = 8'(BANK_ROM);
    localparam logic        DEF_PF_W0   = 1'b1;

    localparam logic [31:0] DEF_BASE_W1 = 32'h18F0_0000;
    localparam logic [31:0] DEF_MASK_W1 = 32'h000F_FFFF;
    localparam logic [7:0]  DEF_BANK_W1 = 8'(BANK_CART);
    localparam logic        DEF_PF_W1   = 1'b0;

    localparam logic [31:0] DEF_BASE_W2 = 32'h1D00_0000;
    localparam logic [31:0] DEF_MASK_W2 = 32'h0000_07FF;
    localparam logic [7:0]  DEF_BANK_W2 = 8'(BANK_EEPROM);
    localparam logic        DEF_PF_W2   = 1'b1;

    // Full attr words as seen through a config read
    localparam logic [31:0] DEF_ATTR_W0 = 32'h8000_0000 | (32'(DEF_PF_W0) << ATTR_PREFETCH_BIT) | 32'(DEF_BANK_W0);
    localparam logic [31:0] DEF_ATTR_W1 = 32'h8000_0000 | (32'(DEF_PF_W1) << ATTR_PREFETCH_BIT) | 32'(DEF_BANK_W1);
    localparam logic [31:0] DEF_ATTR_W2 = 32'h8000_0000 | (32'(DEF_PF_W2) << ATTR_PREFETCH_BIT) | 32'(DEF_BANK_W2);

    function automatic logic [31:0] default_base(input int unsigned idx);
        case (idx)
            0:       return DEF_BASE_W0;
            1:       return DEF_BASE_W1;
            2:       return DEF_BASE_W2;
            default: return '0;
        endcase
    endfunction

    function automatic logic [31:0] default_mask(input int unsigned idx);
        case (idx)
            0:       return DEF_MASK_W0;
            1:       return DEF_MASK_W1;
            2:       return DEF_MASK_W2;
            default: return '0;
        endcase
    endfunction

    function automatic logic [7:0] default_bank(input int unsigned idx);
        case (idx)
            0:       return DEF_BANK_W0;
            1:       return DEF_BANK_W1;
            2:       return DEF_BANK_W2;
            default: return '0;
        endcase
    endfunction

    function automatic logic default_prefetch(input int unsigned idx);
        case (idx)
            0:       return DEF_PF_W0;
            1:       return DEF_PF_W1;
            2:       return DEF_PF_W2;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic default_enable(input int unsigned idx);
        return (idx < 3);
    endfunction

endpackage

// File: rtl/n64_window_match.sv
// n64_window_match
//   Combinational compare of one address against one decode window.
//   Ports:
//     addr_i   : address to decode
//     base_i   : window base (bits under mask_i are ignored)
//     mask_i   : window mask (set bits form the in-window offset)
//     enable_i : window enable
//     match_o  : address lies inside an enabled window
//     offset_o : addr_i & mask_i when matched, else 0
module n64_window_match #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] mask_i,
    input  logic              enable_i,
    output logic              match_o,
    output logic [ADDR_W-1:0] offset_o
);

    always_comb begin
        match_o  = enable_i && ((addr_i & ~mask_i) == (base_i & ~mask_i));
        offset_o = match_o ? (addr_i & mask_i) : '0;
    end

endmodule

// File: rtl/n64_address_decoder.sv
// n64_address_decoder
//   Registered, runtime-programmable PI address decoder with an
//   auto-incrementing address counter.
//   Ports:
//     i_clk, i_reset_n      : clock, synchronous active-low reset
//     i_address_load/_address: load the counter with a PI address
//     i_advance             : step the counter by STEP bytes
//     o_valid               : decode outputs valid (sticky until reset)
//     o_address             : current counter value
//     o_bank/o_prefetch     : decoded bank id and its prefetch permission
//     o_offset              : bank-relative offset (address & window mask)
//     i_cfg_*               : config write/read of per-window base/mask/attr
//     o_cfg_rdata           : registered config read data
module n64_address_decoder
    import n64_decoder_pkg::*;
#(
    parameter int unsigned NUM_WINDOWS = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned BANK_W      = 4,
    parameter int unsigned STEP        = 2
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_address_load,
    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_advance,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_address,
    output logic [BANK_W-1:0] o_bank,
    output logic              o_prefetch,
    output logic [ADDR_W-1:0] o_offset,
    input  logic              i_cfg_write,
    input  logic              i_cfg_read,
    input  logic [3:0]        i_cfg_window,
    input  logic [1:0]        i_cfg_reg,
    input  logic [31:0]       i_cfg_wdata,
    output logic [31:0]       o_cfg_rdata
);

    // Per-window configuration
    logic [ADDR_W-1:0] win_base_q [NUM_WINDOWS];
    logic [ADDR_W-1:0] win_mask_q [NUM_WINDOWS];
    logic [BANK_W-1:0] win_bank_q [NUM_WINDOWS];
    logic              win_pf_q   [NUM_WINDOWS];
    logic              win_en_q   [NUM_WINDOWS];

    // Per-window compare results for the next address
    logic              win_match  [NUM_WINDOWS];
    logic [ADDR_W-1:0] win_offset [NUM_WINDOWS];

    // Output registers and their next-state values
    logic              valid_q;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [BANK_W-1:0] bank_q,   bank_d;
    logic              prefetch_q, prefetch_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [31:0]       cfg_rdata_q, cfg_rdata_d;

    // Next counter value; load wins over advance, advance wraps naturally
    always_comb begin
        addr_d = addr_q;
        if (i_address_load) begin
            addr_d = i_address;
        end else if (i_advance) begin
            addr_d = addr_q + ADDR_W'(STEP);
        end
    end

    // Decode the next address against the current (pre-write) config
    for (genvar g = 0; g < NUM_WINDOWS; g++) begin : g_win
        n64_window_match #(
            .ADDR_W (ADDR_W)
        ) u_match (
            .addr_i   (addr_d),
            .base_i   (win_base_q[g]),
            .mask_i   (win_mask_q[g]),
            .enable_i (win_en_q[g]),
            .match_o  (win_match[g]),
            .offset_o (win_offset[g])
        );
    end

    // Ascending scan: the last matching window, i.e. the highest index, wins
    always_comb begin
        bank_d     = '0;
        prefetch_d = 1'b0;
        offset_d   = '0;
        for (int unsigned i = 0; i < NUM_WINDOWS; i++) begin
            if (win_match[i]) begin
                bank_d     = win_bank_q[i];
                prefetch_d = win_pf_q[i];
                offset_d   = win_offset[i];
            end
        end
    end

    // Config read mux; out-of-range window or reserved reg reads 0
    always_comb begin
        cfg_rdata_d = '0;
        for (int unsigned i = 0; i < NUM_WINDOWS; i++) begin
            if (i_cfg_window == 4'(i)) begin
                case (cfg_reg_e'(i_cfg_reg))
                    CFG_BASE: cfg_rdata_d = 32'(win_base_q[i]);
                    CFG_MASK: cfg_rdata_d = 32'(win_mask_q[i]);
                    CFG_ATTR: begin
                        cfg_rdata_d[BANK_W-1:0]        = win_bank_q[i];
                        cfg_rdata_d[ATTR_PREFETCH_BIT] = win_pf_q[i];
                        cfg_rdata_d[ATTR_ENABLE_BIT]   = win_en_q[i];
                    end
                    default:  cfg_rdata_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            valid_q     <= 1'b0;
            addr_q      <= '0;
            bank_q      <= '0;
            prefetch_q  <= 1'b0;
            offset_q    <= '0;
            cfg_rdata_q <= '0;
            for (int unsigned i = 0; i < NUM_WINDOWS; i++) begin
                win_base_q[i] <= ADDR_W'(default_base(i));
                win_mask_q[i] <= ADDR_W'(default_mask(i));
                win_bank_q[i] <= BANK_W'(default_bank(i));
                win_pf_q[i]   <= default_prefetch(i);
                win_en_q[i]   <= default_enable(i);
            end
        end else begin
            if (i_address_load || i_advance) begin
                valid_q    <= 1'b1;
                addr_q     <= addr_d;
                bank_q     <= bank_d;
                prefetch_q <= prefetch_d;
                offset_q   <= offset_d;
            end
            if (i_cfg_read) begin
                cfg_rdata_q <= cfg_rdata_d;
            end
            if (i_cfg_write) begin
                for (int unsigned i = 0; i < NUM_WINDOWS; i++) begin
                    if (i_cfg_window == 4'(i)) begin
                        case (cfg_reg_e'(i_cfg_reg))
                            CFG_BASE: win_base_q[i] <= ADDR_W'(i_cfg_wdata);
                            CFG_MASK: win_mask_q[i] <= ADDR_W'(i_cfg_wdata);
                            CFG_ATTR: begin
                                win_bank_q[i] <= i_cfg_wdata[BANK_W-1:0];
                                win_pf_q[i]   <= i_cfg_wdata[ATTR_PREFETCH_BIT];
                                win_en_q[i]   <= i_cfg_wdata[ATTR_ENABLE_BIT];
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign o_valid     = valid_q;
    assign o_address   = addr_q;
    assign o_bank      = bank_q;
    assign o_prefetch  = prefetch_q;
    assign o_offset    = offset_q;
    assign o_cfg_rdata = cfg_rdata_q;

endmodule

// File: tb/tb_n64_address_decoder.sv
// tb_n64_address_decoder
//   Directed vectors with hand-computed decode results. Stimulus pushes the
//   expected response into a queue; a monitor pops and compares after every
//   edge on which the DUT updates its decode or config read data.
module tb_n64_address_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        addr_load;
    logic [31:0] addr_in;
    logic        advance;
    logic        valid;
    logic [31:0] addr_out;
    logic [3:0]  bank;
    logic        prefetch;
    logic [31:0] offset;
    logic        cfg_write;
    logic        cfg_read;
    logic [3:0]  cfg_window;
    logic [1:0]  cfg_reg;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;

    always #5 clk = ~clk;

    n64_address_decoder #(
        .NUM_WINDOWS (4),
        .ADDR_W      (32),
        .BANK_W      (4),
        .STEP        (2)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_address_load (addr_load),
        .i_address      (addr_in),
        .i_advance      (advance),
        .o_valid        (valid),
        .o_address      (addr_out),
        .o_bank         (bank),
        .o_prefetch     (prefetch),
        .o_offset       (offset),
        .i_cfg_write    (cfg_write),
        .i_cfg_read     (cfg_read),
        .i_cfg_window   (cfg_window),
        .i_cfg_reg      (cfg_reg),
        .i_cfg_wdata    (cfg_wdata),
        .o_cfg_rdata    (cfg_rdata)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  bank;
        logic        pf;
        logic [31:0] off;
    } dec_t;

    dec_t        dec_q[$];
    logic [31:0] rd_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: decides at the edge whether an update happened, compares mid-cycle
    initial begin : monitor
        logic upd;
        logic rd;
        dec_t e;
        logic [31:0] er;
        forever begin
            @(posedge clk);
            upd = rst_n && (addr_load || advance);
            rd  = rst_n && cfg_read;
            @(negedge clk);
            if (upd) begin
                if (dec_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL dec_unexpected: got update at %08h expected none", addr_out);
                end else begin
                    e = dec_q.pop_front();
                    chk("valid",    32'(valid),    32'd1);
                    chk("address",  addr_out,      e.addr);
                    chk("bank",     32'(bank),     32'(e.bank));
                    chk("prefetch", 32'(prefetch), 32'(e.pf));
                    chk("offset",   offset,        e.off);
                end
            end
            if (rd) begin
                if (rd_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rd_unexpected: got read %08h expected none", cfg_rdata);
                end else begin
                    er = rd_q.pop_front();
                    chk("cfg_rdata", cfg_rdata, er);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_dec(input logic [31:0] a, input logic [3:0] b, input logic p, input logic [31:0] o);
        dec_t e;
        e.addr = a; e.bank = b; e.pf = p; e.off = o;
        dec_q.push_back(e);
    endtask

    task automatic do_load(input logic [31:0] a, input logic adv,
                           input logic [31:0] ea, input logic [3:0] eb, input logic ep, input logic [31:0] eo);
        addr_load = 1'b1; addr_in = a; advance = adv;
        push_dec(ea, eb, ep, eo);
        tick();
        addr_load = 1'b0; advance = 1'b0;
    endtask

    task automatic do_adv(input logic [31:0] ea, input logic [3:0] eb, input logic ep, input logic [31:0] eo);
        advance = 1'b1;
        push_dec(ea, eb, ep, eo);
        tick();
        advance = 1'b0;
    endtask

    task automatic cfg_wr(input logic [3:0] w, input logic [1:0] r, input logic [31:0] d);
        cfg_write = 1'b1; cfg_window = w; cfg_reg = r; cfg_wdata = d;
        tick();
        cfg_write = 1'b0;
    endtask

    task automatic cfg_rd(input logic [3:0] w, input logic [1:0] r, input logic [31:0] exp);
        cfg_read = 1'b1; cfg_window = w; cfg_reg = r;
        rd_q.push_back(exp);
        tick();
        cfg_read = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"},    32'(valid),    32'd0);
        chk({tag, "_address"},  addr_out,      32'd0);
        chk({tag, "_bank"},     32'(bank),     32'd0);
        chk({tag, "_prefetch"}, 32'(prefetch), 32'd0);
        chk({tag, "_offset"},   offset,        32'd0);
        chk({tag, "_rdata"},    cfg_rdata,     32'd0);
    endtask

    initial begin : stimulus
        rst_n = 1'b0; addr_load = 1'b0; addr_in = '0; advance = 1'b0;
        cfg_write = 1'b0; cfg_read = 1'b0; cfg_window = '0; cfg_reg = '0; cfg_wdata = '0;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        chk("pre_load_valid", 32'(valid), 32'd0);

        // ROM window, first transaction
        do_load(32'h1000_0000, 1'b0, 32'h1000_0000, 4'd1, 1'b1, 32'h0000_0000);

        // Burst crossing the top of the ROM window
        do_load(32'h13FF_FFFC, 1'b0, 32'h13FF_FFFC, 4'd1, 1'b1, 32'h03FF_FFFC);
        do_adv(32'h13FF_FFFE, 4'd1, 1'b1, 32'h03FF_FFFE);
        do_adv(32'h1400_0000, 4'd0, 1'b0, 32'h0000_0000);

        // Load beats a simultaneous advance
        do_load(32'h18F0_1234, 1'b1, 32'h18F0_1234, 4'd2, 1'b0, 32'h0000_1234);

        // Program W3 over the EEPROM window; enabling write coincides with a load
        cfg_wr(4'd3, 2'd0, 32'h1D00_0000);
        cfg_wr(4'd3, 2'd1, 32'h0000_FFFF);
        cfg_write = 1'b1; cfg_window = 4'd3; cfg_reg = 2'd2; cfg_wdata = 32'h8000_0104;
        do_load(32'h1D00_0010, 1'b0, 32'h1D00_0010, 4'd3, 1'b1, 32'h0000_0010);
        cfg_write = 1'b0;
        do_load(32'h1D00_0010, 1'b0, 32'h1D00_0010, 4'd4, 1'b1, 32'h0000_0010);

        // Counter wrap
        do_load(32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFE, 4'd0, 1'b0, 32'h0000_0000);
        do_adv(32'h0000_0000, 4'd0, 1'b0, 32'h0000_0000);

        // Config reads, invalid targets, ignored writes
        cfg_rd(4'd1, 2'd1, 32'h000F_FFFF);
        cfg_rd(4'd9, 2'd0, 32'h0000_0000);
        cfg_rd(4'd3, 2'd2, 32'h8000_0104);
        cfg_wr(4'd0, 2'd3, 32'hFFFF_FFFF);
        cfg_wr(4'd9, 2'd0, 32'hFFFF_FFFF);
        cfg_rd(4'd0, 2'd3, 32'h0000_0000);
        cfg_rd(4'd0, 2'd0, 32'h1000_0000);
        cfg_wr(4'd1, 2'd2, 32'hFFFF_FFFF);
        cfg_rd(4'd1, 2'd2, 32'h8000_010F);

        // Read and write of the same register: read sees the old value
        cfg_write = 1'b1; cfg_wdata = 32'h1234_5678;
        cfg_rd(4'd2, 2'd0, 32'h1D00_0000);
        cfg_write = 1'b0;
        cfg_rd(4'd2, 2'd0, 32'h1234_5678);

        // Disabling W0 leaves the held decode alone until the next load
        do_load(32'h1000_0000, 1'b0, 32'h1000_0000, 4'd1, 1'b1, 32'h0000_0000);
        cfg_wr(4'd0, 2'd2, 32'h0000_0101);
        tick();
        chk("hold_bank",     32'(bank),     32'd1);
        chk("hold_prefetch", 32'(prefetch), 32'd1);
        do_load(32'h1000_0000, 1'b0, 32'h1000_0000, 4'd0, 1'b0, 32'h0000_0000);

        // Reset mid-burst restores outputs and the default window map
        do_load(32'h1D00_0020, 1'b0, 32'h1D00_0020, 4'd4, 1'b1, 32'h0000_0020);
        advance = 1'b1; rst_n = 1'b0;
        tick();
        advance = 1'b0;
        chk_reset_outputs("midrst");
        rst_n = 1'b1;
        cfg_rd(4'd0, 2'd2, 32'h8000_0101);
        cfg_rd(4'd3, 2'd0, 32'h0000_0000);
        cfg_rd(4'd2, 2'd0, 32'h1D00_0000);
        cfg_rd(4'd1, 2'd2, 32'h8000_0002);
        do_load(32'h1D00_0010, 1'b0, 32'h1D00_0010, 4'd3, 1'b1, 32'h0000_0010);

        // Drain with a bounded wait
        for (int k = 0; k < 20 && (dec_q.size() != 0 || rd_q.size() != 0); k++) begin
            tick();
        end
        if (dec_q.size() != 0 || rd_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", dec_q.size(), rd_q.size());
        end
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/n64_address_decoder.md
Name: n64_address_decoder

Overview:
Registered, runtime-programmable PI address decoder with an auto-incrementing address counter. Latches the PI address when the address phase completes, steps it 2 bytes per data word, and re-decodes on every step. Outputs the target bank, the prefetch flag and the bank-relative offset. Sits between the PI bus front-end and the bank request logic. A config port lets the CPU-side controller relocate, resize or disable windows without a new bitstream.

Parameters:
NUM_WINDOWS, 4, number of decode windows (1..16)
ADDR_W, 32, address and counter width
BANK_W, 4, bank id width; bank 0 = invalid
STEP, 2, byte increment per i_advance

Ports:
i_clk  in  1  clock
i_reset_n  in  1  synchronous active-low reset
i_address_load  in  1  pulse: load i_address into the counter
i_address  in  ADDR_W  PI address
i_advance  in  1  pulse: counter += STEP
o_valid  out  1  decode outputs valid
o_address  out  ADDR_W  current counter value
o_bank  out  BANK_W  decoded bank
o_prefetch  out  1  bank allows prefetch
o_offset  out  ADDR_W  address & window mask
i_cfg_write  in  1  config write strobe
i_cfg_read  in  1  config read strobe
i_cfg_window  in  4  window index
i_cfg_reg  in  2  0=base, 1=mask, 2=attr, 3=reserved
i_cfg_wdata  in  32  write data
o_cfg_rdata  out  32  read data, registered

Behaviour:
- Reset, on the first i_clk edge with i_reset_n=0: o_valid=0, o_address=0, o_bank=0, o_prefetch=0, o_offset=0, o_cfg_rdata=0.
- Reset also reloads the window defaults:
  - W0: base 1000_0000, mask 03FF_FFFF, bank 1, prefetch 1, enabled.
  - W1: base 18F0_0000, mask 000F_FFFF, bank 2, prefetch 0, enabled.
  - W2: base 1D00_0000, mask 0000_07FF, bank 3, prefetch 1, enabled.
  - W3 and above: all zero, disabled.
- Reset mid-burst: all outputs and config return to reset values on the same edge.
- Attr register format: [BANK_W-1:0] bank, [8] prefetch, [31] enable. Other bits read 0.
- Window match: enable=1 and (addr & ~mask) == (base & ~mask). Base bits under the mask are ignored.
- Priority: when several windows match, the highest index wins. No match gives bank 0, prefetch 0, offset 0.
- Next-address selection, evaluated combinationally:
  - i_address_load=1: i_address. Load wins over a simultaneous advance.
  - else i_advance=1: o_address+STEP, wrapping modulo 2^ADDR_W (FFFF_FFFE+2 = 0).
  - else: hold.
- On a load or advance edge:
  - o_address, o_bank, o_prefetch and o_offset are registered together from the decode of the next address.
  - Latency is 1 cycle from the strobe.
  - o_valid is set to 1 and stays 1 until reset.
- With no load or advance, decode outputs hold.
- Config writes do not re-decode the held address. They affect only the next load or advance.
- A write and a load/advance in the same cycle: the decode uses the pre-write config.
- A burst that crosses a window edge switches bank on the advance that crosses it. Example: 13FF_FFFE+2 = 1400_0000 gives bank 0.
- Config write: the selected register updates on the edge.
  - i_cfg_window >= NUM_WINDOWS, or i_cfg_reg=3: write ignored.
- Config read: o_cfg_rdata is updated on the edge after i_cfg_read.
  - Invalid window/reg reads 0.
  - Without a read, o_cfg_rdata holds its value.
- Read and write of the same register in one cycle: the read returns the old value.

Decomposition:
- Package n64_decoder_pkg holds:
  - bank id constants (INVALID=0, ROM=1, CART=2, EEPROM=3);
  - cfg register indices;
  - attr bit positions;
  - reset-default base/mask/attr constants.
- Sub-module n64_window_match: purely combinational per-window compare, outputs match and offset. Instantiated NUM_WINDOWS times; the priority select lives in the parent.

Test Plan:
- Reset, then load 1000_0000 -> next cycle o_valid=1, bank=1, prefetch=1, offset=0; before the load, o_valid=0.
- Load 13FF_FFFC, advance ×2 -> bank stays 1 at 13FF_FFFE, becomes 0 at 1400_0000, offset 0.
- Load 18F0_1234 with advance high in the same cycle -> o_address=18F0_1234, bank=2, prefetch=0, offset 0000_1234.
- Write W3 base 1D00_0000, mask 0000_FFFF, attr 8000_0104 while loading 1D00_0010 -> that decode gives bank 3 (old config). A reload of 1D00_0010 gives bank 4, prefetch 1 (W3 outranks W2).
- Load FFFF_FFFE, advance -> o_address=0000_0000, bank 0.
- Read W1 mask -> 000F_FFFF one cycle later; read window 9 (NUM_WINDOWS=4) -> 0; write attr enable=0 to W0, reload 1000_0000 -> bank 0.
